addr_fr_serial: RTL

//  Parametrised, fault-resilient unsigned adder. Computes A+B digit-serially, DIGIT bits per cycle.

---
 rtl/addr_fr_serial.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/addr_fr_serial.sv
// addr_fr_serial -- fault-resilient digit-serial unsigned adder.
//   Adds a+b DIGIT bits per cycle, LSB digit first. Each digit is formed by
//   two replica adders whose {carry, digit} results are compared. On a
//   mismatch the digit is recomputed up to MAX_RETRY times. Once the retries
//   are used up, replica P is committed anyway and the fault is flagged fatal.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (in_ready = idle)
//   a, b                  WIDTH-bit unsigned operands, sampled at accept
//   inj_en, inj_mask      XOR fault injection on replica Q's result
//   out_valid / out_ready result handshake
//   sum                   WIDTH+1-bit result, MSB = carry-out
//   fault_seen            any replica mismatch in this operation
//   fault_fatal           some digit exhausted its retries
//   retry_cnt             total retries in this operation, saturating

module addr_fr_serial_rep #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT:0]   s
);
   assign s = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

module addr_fr_serial #(
   parameter int WIDTH     = 8,
   parameter int DIGIT     = 2,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             inj_en,
   input  logic [DIGIT:0]   inj_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             fault_seen,
   output logic             fault_fatal,
   output logic [7:0]       retry_cnt
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] a_q, b_q;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [RW-1:0]    dig_retry;

   logic [DIGIT-1:0]      a_d, b_d;
   logic [1:0][DIGIT:0]   rep_s;
   logic [DIGIT:0]        p, q;
   int                    base;
   logic                  mism, can_retry, commit, last;

   // Current digit slice of the latched operands.
   always_comb begin
      base = int'(idx) * DIGIT;
      a_d  = a_q[base +: DIGIT];
      b_d  = b_q[base +: DIGIT];
   end

   // Two identical replicas; any disagreement between them is treated as a transient fault.
   for (genvar r = 0; r < 2; r++) begin : g_rep
      addr_fr_serial_rep #(.DIGIT(DIGIT)) u_rep (
         .a   (a_d),
         .b   (b_d),
         .cin (carry),
         .s   (rep_s[r])
      );
   end

   always_comb begin
      p         = rep_s[0];
      q         = rep_s[1] ^ (inj_en ? inj_mask : '0);
      mism      = (p != q);
      can_retry = (dig_retry < RW'(MAX_RETRY));
      // Once retries are exhausted, P is committed exactly as it would be on a match.
      commit    = !mism || !can_retry;
      last      = (idx == IW'(NDIG - 1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)       state_nx = CALC;
         CALC:    if (commit && last) state_nx = DONE;
         DONE:    if (out_ready)      state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   // Output decode (state is registered, so out_valid comes straight off a flop decode)
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         carry       <= 1'b0;
         idx         <= '0;
         dig_retry   <= '0;
         sum         <= '0;
         fault_seen  <= 1'b0;
         fault_fatal <= 1'b0;
         retry_cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q         <= a;
               b_q         <= b;
               carry       <= 1'b0;
               idx         <= '0;
               dig_retry   <= '0;
               sum         <= '0;
               fault_seen  <= 1'b0;
               fault_fatal <= 1'b0;
               retry_cnt   <= '0;
            end
            CALC: begin
               if (mism) begin
                  fault_seen <= 1'b1;
                  if (can_retry) begin
                     dig_retry <= dig_retry + 1'b1;
                     if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                  end else begin
                     fault_fatal <= 1'b1;
                  end
               end
               if (commit) begin
                  sum[base +: DIGIT] <= p[DIGIT-1:0];
                  carry              <= p[DIGIT];
                  dig_retry          <= '0;
                  if (last) begin
                     sum[WIDTH] <= p[DIGIT];
                     idx        <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
